keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner: drives one row low at a time, synchronises and debounces the column inputs, and rejects multi-key (ghost) presses. It emits a linear key index per press, with optional auto-repeat, into a small FIFO read through a valid/ready handshake. It replaces the fixed 4x4 sweep/debounce pair and sits between the board keypad pins and the calculator input decoder.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_scanner_if.sv | 14 +
 rtl/keypad_event_fifo.sv | 57 +++++
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and the calculator input decoder.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan     = 2'd0,
    StDebounce = 2'd1,
    StHeld     = 2'd2,
    StRelease  = 2'd3
  } scan_state_e;

  function automatic int unsigned key_width(int unsigned rows, int unsigned cols);
    return $clog2(rows * cols);
  endfunction

  // Calculator key indices on the 4x4 board layout (row*4+col).
  localparam int unsigned Key1      = 0;
  localparam int unsigned Key2      = 1;
  localparam int unsigned Key3      = 2;
  localparam int unsigned KeyAdd    = 3;
  localparam int unsigned Key4      = 4;
  localparam int unsigned Key5      = 5;
  localparam int unsigned Key6      = 6;
  localparam int unsigned KeySub    = 7;
  localparam int unsigned Key7      = 8;
  localparam int unsigned Key8      = 9;
  localparam int unsigned Key9      = 10;
  localparam int unsigned KeyMul    = 11;
  localparam int unsigned KeyClear  = 12;
  localparam int unsigned Key0      = 13;
  localparam int unsigned KeyEquals = 14;
  localparam int unsigned KeyDiv    = 15;

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event stream and status from the keypad scanner to its consumer.
interface keypad_scanner_if #(
  parameter int unsigned KW = 4
);
  logic [KW-1:0] key_data;
  logic          key_valid;
  logic          key_ready;
  logic          key_down;
  logic          ghost;
  logic          overflow;

  modport master (output key_data, key_valid, key_down, ghost, overflow, input key_ready);
  modport slave  (input key_data, key_valid, key_down, ghost, overflow, output key_ready);
endinterface

// File: rtl/keypad_event_fifo.sv
// Small synchronous key-event FIFO; flags a push that had to be dropped because it was full.
module keypad_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]    count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push, do_pop;

  assign full    = (count_q == NW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row sweep, column sync/debounce, ghost rejection, auto-repeat, event FIFO.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 4,
  parameter int unsigned SCAN_DIV    = 250000,
  parameter int unsigned DEBOUNCE    = 30,
  parameter int unsigned REPEAT_DLY  = 0,
  parameter int unsigned REPEAT_RATE = 5000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_out,
  keypad_scanner_if.master  key_if
);
  localparam int unsigned KW     = key_width(ROWS, COLS);
  localparam int unsigned RW     = $clog2(ROWS);
  localparam int unsigned CW     = $clog2(COLS);
  localparam int unsigned DivW   = $clog2(SCAN_DIV);
  localparam int unsigned CntW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam int unsigned RepDly = (REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0;
  localparam bit          RepEn  = (REPEAT_DLY != 0);

  logic [COLS-1:0] col_meta, col_s, pat_q;
  logic [DivW-1:0] div_q;
  logic            tick;
  scan_state_e     state_q;
  logic [ROWS-1:0] row_out_q;
  logic [RW-1:0]   row_idx_q;
  logic [CW-1:0]   col_idx_q, low_col;
  logic [CntW-1:0] cnt_q;
  logic [RepW-1:0] rep_q;
  logic            rep_first_q, key_down_q, ghost_q, overflow_q;
  logic            all_high, one_low, rep_fire, push, pop;
  logic [KW-1:0]   key_code, fifo_rdata;
  logic            fifo_full, fifo_empty, fifo_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= '1;
      col_s    <= '1;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  // Free-running: a return to SCAN waits for the next natural tick.
  assign tick = (div_q == DivW'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    low_col = '0;
    for (int i = 0; i < int'(COLS); i++) begin
      if (!col_s[i]) low_col = CW'(i);
    end
  end

  assign all_high = &col_s;
  assign one_low  = ($countones(~col_s) == 1);
  assign key_code = KW'(row_idx_q) * KW'(COLS) + KW'(col_idx_q);
  assign rep_fire = RepEn && (state_q == StHeld) &&
                    (rep_q == (rep_first_q ? RepW'(RepDly) : RepW'(REPEAT_RATE - 1)));
  assign push     = ((state_q == StDebounce) && (col_s == pat_q) &&
                     (cnt_q == CntW'(DEBOUNCE - 1))) || rep_fire;
  assign pop      = !fifo_empty && key_if.key_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StScan;
      row_out_q   <= {{(ROWS-1){1'b1}}, 1'b0};
      row_idx_q   <= '0;
      col_idx_q   <= '0;
      pat_q       <= '1;
      cnt_q       <= '0;
      rep_q       <= '0;
      rep_first_q <= 1'b1;
      key_down_q  <= 1'b0;
      ghost_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      ghost_q    <= 1'b0;
      overflow_q <= overflow_q | fifo_drop;
      case (state_q)
        StScan: begin
          if (tick) begin
            if (one_low) begin
              col_idx_q <= low_col;
              pat_q     <= col_s;
              cnt_q     <= '0;
              state_q   <= StDebounce;
            end else begin
              ghost_q   <= !all_high;
              row_out_q <= {row_out_q[ROWS-2:0], row_out_q[ROWS-1]};
              row_idx_q <= (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + 1'b1;
            end
          end
        end
        StDebounce: begin
          if (col_s != pat_q) begin
            state_q <= StScan;
          end else if (cnt_q == CntW'(DEBOUNCE - 1)) begin
            state_q     <= StHeld;
            key_down_q  <= 1'b1;
            rep_q       <= '0;
            rep_first_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHeld: begin
          if (rep_fire) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
          end else if (RepEn) begin
            rep_q <= rep_q + 1'b1;
          end
          if (all_high) begin
            cnt_q   <= '0;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          if (!all_high) begin
            state_q <= StHeld;
          end else if (cnt_q == CntW'(DEBOUNCE - 1)) begin
            state_q    <= StScan;
            key_down_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

  keypad_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (key_code),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  drop_only_when_full: assert property (@(posedge clk) disable iff (rst) fifo_drop |-> fifo_full);

  assign row_out          = row_out_q;
  assign key_if.key_data  = fifo_rdata;
  assign key_if.key_valid = !fifo_empty;
  assign key_if.key_down  = key_down_q;
  assign key_if.ghost     = ghost_q;
  assign key_if.overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios plus randomized presses against a key-event model.
module tb_keypad_scanner;
  localparam int unsigned DEBOUNCE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  row_out, rep_row_out, col_in, rep_col_in;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned ghost_cnt = 0;
  logic [3:0]  got_q[$];
  logic [3:0]  exp_q[$];
  int unsigned rep_t[$];
  logic [3:0]  rep_d[$];

  keypad_scanner_if #(.KW(4)) key_if ();
  keypad_scanner_if #(.KW(4)) rep_if ();
  assign key_if.key_ready = ready;
  assign rep_if.key_ready = 1'b1;

  // Ideal switch matrix: a pressed key pulls its column low while its row is driven low.
  function automatic logic [3:0] matrix(logic [3:0] rows, logic [15:0] keys);
    logic [3:0] cols;
    cols = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && keys[r*4+c]) cols[c] = 1'b0;
    return cols;
  endfunction

  assign col_in     = matrix(row_out, pressed);
  assign rep_col_in = matrix(rep_row_out, pressed);

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DLY(0), .REPEAT_RATE(5), .FIFO_DEPTH(2)
  ) u_dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out), .key_if(key_if)
  );

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEBOUNCE),
    .REPEAT_DLY(10), .REPEAT_RATE(5), .FIFO_DEPTH(2)
  ) u_rep (
    .clk(clk), .rst(rst), .col_in(rep_col_in), .row_out(rep_row_out), .key_if(rep_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (key_if.key_valid && key_if.key_ready) got_q.push_back(key_if.key_data);
      if (key_if.ghost) ghost_cnt++;
      if (rep_if.key_valid) begin
        rep_t.push_back(cyc);
        rep_d.push_back(rep_if.key_data);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rstep(input int unsigned n);
    repeat (n) begin
      ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
  endtask

  task automatic wait_down(input logic lvl, input string tag);
    int unsigned n = 0;
    while (key_if.key_down !== lvl && n < 200) begin
      step(1);
      n++;
    end
    check(tag, key_if.key_down, lvl);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned n, t0, g0, r, c, c2;
    int unsigned hold;
    logic        prev_down;
    bit          gh;
    int unsigned rep_off[5] = '{0, 10, 15, 20, 25};

    step(2);
    check("rst_row", row_out, 4'b1110);
    check("rst_valid", key_if.key_valid, 0);
    check("rst_data", key_if.key_data, 0);
    check("rst_down", key_if.key_down, 0);
    check("rst_ghost", key_if.ghost, 0);
    check("rst_ovf", key_if.overflow, 0);
    rst = 1'b0;
    step(3);

    // Single press of row2/col1.
    got_q.delete();
    pressed = '0;
    pressed[9] = 1'b1;
    n = 0;
    prev_down = 1'b0;
    while (key_if.key_valid !== 1'b1 && n < 100) begin
      prev_down = key_if.key_down;
      step(1);
      n++;
    end
    check("t1_valid", key_if.key_valid, 1);
    check("t1_data", key_if.key_data, 9);
    check("t1_down_with_valid", key_if.key_down, 1);
    check("t1_down_before", prev_down, 0);
    step(1);
    check("t1_valid_one_cycle", key_if.key_valid, 0);
    step(20);
    check("t1_down_held", key_if.key_down, 1);
    pressed = '0;
    n = 0;
    while (key_if.key_down === 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    check("t1_release_latency", n, 2 + 1 + DEBOUNCE);
    step(6);
    check("t1_count", got_q.size(), 1);

    // Bouncing contact, then stable.
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      pressed = '0;
      pressed[9] = (i % 2 == 0);
      step(2);
    end
    check("t2_no_early_push", got_q.size() + key_if.key_valid, 0);
    wait_down(1'b1, "t2_down");
    step(10);
    pressed = '0;
    wait_down(1'b0, "t2_up");
    step(8);
    check("t2_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t2_code", got_q[0], 9);

    // Two keys in row0: ghost.
    got_q.delete();
    pressed = 16'h0003;
    n = 0;
    while (key_if.ghost !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check("t3_ghost_seen", key_if.ghost, 1);
    check("t3_row_advance", row_out, 4'b1101);
    step(1);
    check("t3_ghost_width", key_if.ghost, 0);
    g0 = ghost_cnt;
    step(64);
    check("t3_ghost_rate", ghost_cnt - g0, 4);
    check("t3_no_push", got_q.size(), 0);
    check("t3_no_down", key_if.key_down, 0);
    pressed = '0;
    step(8);

    // Overflow with the consumer stalled.
    ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      pressed = '0;
      pressed[5 + 5*i] = 1'b1;
      wait_down(1'b1, "t4_down");
      step(3);
      pressed = '0;
      wait_down(1'b0, "t4_up");
      step(6);
      if (i == 1) check("t4_no_ovf_yet", key_if.overflow, 0);
    end
    check("t4_valid", key_if.key_valid, 1);
    check("t4_head", key_if.key_data, 5);
    check("t4_ovf", key_if.overflow, 1);
    ready = 1'b1;
    step(4);
    check("t4_pop_count", got_q.size(), 2);
    if (got_q.size() > 1) begin
      check("t4_pop0", got_q[0], 5);
      check("t4_pop1", got_q[1], 10);
    end
    check("t4_ovf_sticky", key_if.overflow, 1);
    check("t4_drained", key_if.key_valid, 0);

    // Reset while a key is held.
    pressed = '0;
    pressed[3] = 1'b1;
    wait_down(1'b1, "t5_down");
    step(5);
    rst = 1'b1;
    #1;
    check("t5_row", row_out, 4'b1110);
    check("t5_down", key_if.key_down, 0);
    check("t5_valid", key_if.key_valid, 0);
    check("t5_ovf", key_if.overflow, 0);
    pressed = '0;
    step(2);
    rst = 1'b0;
    step(4);

    // Randomized presses against the key-event model.
    got_q.delete();
    exp_q.delete();
    for (int it = 0; it < 24; it++) begin
      r  = $urandom_range(0, 3);
      c  = $urandom_range(0, 3);
      gh = ($urandom_range(0, 4) == 0);
      g0 = ghost_cnt;
      pressed = '0;
      pressed[r*4+c] = 1'b1;
      if (gh) begin
        c2 = (c + 1 + $urandom_range(0, 2)) % 4;
        pressed[r*4+c2] = 1'b1;
      end else begin
        exp_q.push_back(4'(r*4+c));
      end
      hold = $urandom_range(40, 60);
      rstep(hold);
      if (gh) check("rnd_ghost", (ghost_cnt - g0) >= 2, 1);
      else    check("rnd_down", key_if.key_down, 1);
      pressed = '0;
      rstep($urandom_range(12, 20));
    end
    ready = 1'b1;
    step(10);
    check("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("rnd_code", got_q[i], exp_q[i]);
    check("rnd_no_ovf", key_if.overflow, 0);

    // Auto-repeat on the second instance; the first must push only once.
    step(30);
    got_q.delete();
    rep_t.delete();
    rep_d.delete();
    pressed = '0;
    pressed[0] = 1'b1;
    n = 0;
    while (rep_if.key_valid !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    check("rep_first", rep_if.key_valid, 1);
    t0 = cyc;
    step(26);
    pressed = '0;
    step(30);
    check("rep_count", rep_t.size(), 5);
    for (int i = 0; i < 5 && i < rep_t.size(); i++) begin
      check("rep_time", rep_t[i] - t0, rep_off[i]);
      check("rep_code", rep_d[i], 0);
    end
    check("norep_count", got_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
